// File: rtl/servo_pkg.sv
// Shared definitions for the servo sweep responders: FSM states and the
// default timing for the arm and marble-dispenser servos.
package servo_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SWEEP_OUT,
        HOLD,
        SWEEP_BACK,
        DONE
    } servo_state_t;

    // 100 MHz clock: 20 ms frame, 1 ms park, 2 ms far
    localparam int unsigned ARM_PERIOD_CYCLES    = 2_000_000;
    localparam int unsigned ARM_MIN_PULSE        = 100_000;
    localparam int unsigned ARM_MAX_PULSE        = 200_000;
    localparam int unsigned ARM_STEP             = 2_000;
    localparam int unsigned ARM_HOLD_FRAMES      = 25;

    localparam int unsigned MARBLE_PERIOD_CYCLES = 2_000_000;
    localparam int unsigned MARBLE_MIN_PULSE     = 100_000;
    localparam int unsigned MARBLE_MAX_PULSE     = 150_000;
    localparam int unsigned MARBLE_STEP          = 5_000;
    localparam int unsigned MARBLE_HOLD_FRAMES   = 10;

endpackage

// File: rtl/servo_sweep_ctrl_if.sv
// Sequencer <-> servo responder handshake plus the servo signal pin.
interface servo_sweep_ctrl_if;
    import servo_pkg::*;

    logic enable;
    logic clear;
    logic done;
    logic busy;
    logic pwm;

    modport master (
        output enable,
        output clear,
        input  done,
        input  busy,
        input  pwm
    );

    modport slave (
        input  enable,
        input  clear,
        output done,
        output busy,
        output pwm
    );

endinterface

// File: rtl/servo_pwm_gen.sv
// Free-running PWM frame counter with a registered width comparator and a
// last-cycle-of-frame strobe used to time width updates.
module servo_pwm_gen
    import servo_pkg::*;
#(
    parameter int unsigned PERIOD_CYCLES = ARM_PERIOD_CYCLES,
    parameter int unsigned W             = $clog2(PERIOD_CYCLES)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] width,
    output logic         pwm,
    output logic         frame_end
);

    logic [W-1:0] frame_cnt;

    assign frame_end = (frame_cnt == W'(PERIOD_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
            pwm       <= 1'b0;
        end else begin
            frame_cnt <= frame_end ? '0 : frame_cnt + W'(1);
            pwm       <= (frame_cnt < width);
        end
    end

endmodule

// File: rtl/servo_sweep_ctrl.sv
// Servo responder: on enable sweeps the PWM width park -> far, holds, sweeps
// back, then raises a sticky done until the sequencer clears it.
module servo_sweep_ctrl
    import servo_pkg::*;
#(
    parameter int unsigned PERIOD_CYCLES = ARM_PERIOD_CYCLES,
    parameter int unsigned MIN_PULSE     = ARM_MIN_PULSE,
    parameter int unsigned MAX_PULSE     = ARM_MAX_PULSE,
    parameter int unsigned STEP          = ARM_STEP,
    parameter int unsigned HOLD_FRAMES   = ARM_HOLD_FRAMES
) (
    input logic              clk,
    input logic              reset,
    servo_sweep_ctrl_if.slave bus
);

    localparam int unsigned W = $clog2(PERIOD_CYCLES);
    localparam logic [W-1:0] MIN_W     = W'(MIN_PULSE);
    localparam logic [W-1:0] MAX_W     = W'(MAX_PULSE);
    localparam logic [W-1:0] HOLD_LAST = W'(HOLD_FRAMES - 1);

    servo_state_t state;
    logic [W-1:0] width;
    logic [W-1:0] hold_cnt;
    logic [W-1:0] width_up;
    logic [W-1:0] width_dn;
    logic         frame_end;
    logic         done_r;
    logic         busy_r;

    assign bus.done = done_r;
    assign bus.busy = busy_r;

    servo_pwm_gen #(
        .PERIOD_CYCLES (PERIOD_CYCLES),
        .W             (W)
    ) u_pwm (
        .clk       (clk),
        .reset     (reset),
        .width     (width),
        .pwm       (bus.pwm),
        .frame_end (frame_end)
    );

    // Clamp against the remaining headroom so width+STEP / width-STEP is
    // only formed when it cannot leave [MIN_PULSE, MAX_PULSE].
    always_comb begin
        width_up = MAX_W;
        if (32'(MAX_W - width) > STEP)
            width_up = width + W'(STEP);
        width_dn = MIN_W;
        if (32'(width - MIN_W) > STEP)
            width_dn = width - W'(STEP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            width    <= MIN_W;
            hold_cnt <= '0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
        end else if (bus.clear) begin
            state    <= IDLE;
            hold_cnt <= '0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
            if (frame_end)
                width <= MIN_W;
        end else begin
            unique case (state)
                IDLE: begin
                    if (frame_end)
                        width <= MIN_W;
                    if (bus.enable) begin
                        state  <= SWEEP_OUT;
                        busy_r <= 1'b1;
                    end
                end
                SWEEP_OUT: begin
                    if (frame_end) begin
                        width <= width_up;
                        if (width_up == MAX_W)
                            state <= HOLD;
                    end
                end
                HOLD: begin
                    if (frame_end) begin
                        if (hold_cnt == HOLD_LAST) begin
                            hold_cnt <= '0;
                            state    <= SWEEP_BACK;
                        end else begin
                            hold_cnt <= hold_cnt + W'(1);
                        end
                    end
                end
                SWEEP_BACK: begin
                    if (frame_end) begin
                        width <= width_dn;
                        if (width_dn == MIN_W) begin
                            state  <= DONE;
                            done_r <= 1'b1;
                            busy_r <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    width <= MIN_W;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_servo_sweep_ctrl.sv
// Bench for servo_sweep_ctrl: two instances (far 30 and far 28) checked each
// cycle against a frame/plan model, plus literal per-frame pulse widths.
module tb_servo_sweep_ctrl;

    localparam int P  = 100;
    localparam int MN = 10;
    localparam int ST = 5;
    localparam int HF = 2;

    logic clk;
    logic rst;
    logic en  [2];
    logic clr [2];
    logic dpwm [2];
    logic dd   [2];
    logic db   [2];

    servo_sweep_ctrl_if bif0 ();
    servo_sweep_ctrl_if bif1 ();

    assign bif0.enable = en[0];
    assign bif0.clear  = clr[0];
    assign bif1.enable = en[1];
    assign bif1.clear  = clr[1];
    assign dpwm[0] = bif0.pwm;
    assign dd[0]   = bif0.done;
    assign db[0]   = bif0.busy;
    assign dpwm[1] = bif1.pwm;
    assign dd[1]   = bif1.done;
    assign db[1]   = bif1.busy;

    servo_sweep_ctrl #(
        .PERIOD_CYCLES (P),
        .MIN_PULSE     (MN),
        .MAX_PULSE     (30),
        .STEP          (ST),
        .HOLD_FRAMES   (HF)
    ) dut_a (
        .clk   (clk),
        .reset (rst),
        .bus   (bif0.slave)
    );

    servo_sweep_ctrl #(
        .PERIOD_CYCLES (P),
        .MIN_PULSE     (MN),
        .MAX_PULSE     (28),
        .STEP          (ST),
        .HOLD_FRAMES   (HF)
    ) dut_b (
        .clk   (clk),
        .reset (rst),
        .bus   (bif1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each sweep is a precomputed list of per-frame widths consumed one per
    // frame boundary; done rises when the list is exhausted.
    int mx [2];
    int m_plan [2][64];
    int m_len  [2];
    int m_pos  [2];
    int m_cnt  [2];
    int m_w    [2];
    int m_mode [2];   // 0 idle, 1 running, 2 finished
    bit m_done [2];
    bit m_busy [2];
    bit m_pwm  [2];
    bit mb_bnd;
    bit mb_nx;

    initial begin
        int n;
        int w;
        mx[0] = 30;
        mx[1] = 28;
        for (int i = 0; i < 2; i++) begin
            n = 0;
            w = MN;
            while (w != mx[i]) begin
                w = (w + ST > mx[i]) ? mx[i] : w + ST;
                m_plan[i][n] = w;
                n = n + 1;
            end
            for (int k = 0; k < HF; k++) begin
                m_plan[i][n] = mx[i];
                n = n + 1;
            end
            while (w != MN) begin
                w = (w - ST < MN) ? MN : w - ST;
                m_plan[i][n] = w;
                n = n + 1;
            end
            m_len[i] = n;
        end
    end

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_cnt[i]  = 0;
                m_w[i]    = MN;
                m_mode[i] = 0;
                m_pos[i]  = 0;
                m_done[i] = 1'b0;
                m_busy[i] = 1'b0;
                m_pwm[i]  = 1'b0;
            end else begin
                mb_bnd = (m_cnt[i] == P - 1);
                mb_nx  = (m_cnt[i] < m_w[i]);
                if (clr[i]) begin
                    m_mode[i] = 0;
                    m_done[i] = 1'b0;
                    m_busy[i] = 1'b0;
                    if (mb_bnd) m_w[i] = MN;
                end else if (m_mode[i] == 0) begin
                    if (mb_bnd) m_w[i] = MN;
                    if (en[i]) begin
                        m_mode[i] = 1;
                        m_busy[i] = 1'b1;
                        m_pos[i]  = 0;
                    end
                end else if (m_mode[i] == 1 && mb_bnd) begin
                    m_w[i]   = m_plan[i][m_pos[i]];
                    m_pos[i] = m_pos[i] + 1;
                    if (m_pos[i] == m_len[i]) begin
                        m_mode[i] = 2;
                        m_done[i] = 1'b1;
                        m_busy[i] = 1'b0;
                    end
                end
                m_cnt[i] = mb_bnd ? 0 : m_cnt[i] + 1;
                m_pwm[i] = mb_nx;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("a_pwm",  dpwm[0], m_pwm[0]);
            check("a_done", dd[0],   m_done[0]);
            check("a_busy", db[0],   m_busy[0]);
            check("b_pwm",  dpwm[1], m_pwm[1]);
            check("b_done", dd[1],   m_done[1]);
            check("b_busy", db[1],   m_busy[1]);
        end
    end

    // ---------------- pulse width measurement ----------------
    int pw  [2][64];
    int pn  [2];
    int run [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (dpwm[i] === 1'b1) begin
                run[i] = run[i] + 1;
            end else if (run[i] > 0) begin
                if (pn[i] < 64) begin
                    pw[i][pn[i]] = run[i];
                    pn[i] = pn[i] + 1;
                end
                run[i] = 0;
            end
        end
    end

    task automatic clear_meas();
        for (int i = 0; i < 2; i++) begin
            pn[i]  = 0;
            run[i] = 0;
            for (int k = 0; k < 64; k++) pw[i][k] = 0;
        end
    endtask

    function automatic int last_pw(input int i);
        return (pn[i] > 0) ? pw[i][pn[i] - 1] : 0;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int i, input int limit);
        int k;
        k = 0;
        while (dd[i] !== 1'b1 && k < limit) begin
            cycles(1);
            k++;
        end
        check("done_wait", dd[i], 1);
    endtask

    task automatic check_sweep(input int i, input int e[10]);
        int s;
        s = 0;
        while (s < 50 && pw[i][s] == MN) s++;
        for (int k = 0; k < 10; k++)
            check(i == 0 ? "a_frame_width" : "b_frame_width", pw[i][s + k], e[k]);
    endtask

    int exp_a [10] = '{15, 20, 25, 30, 30, 30, 25, 20, 15, 10};
    int exp_b [10] = '{15, 20, 25, 28, 28, 28, 23, 18, 13, 10};

    initial begin
        int k;
        int base;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            en[i]  = 1'b0;
            clr[i] = 1'b0;
        end
        clear_meas();
        cycles(1);
        chk_on = 1'b1;
        check("rst_pwm",  dpwm[0], 0);
        check("rst_done", dd[0],   0);
        check("rst_busy", db[0],   0);
        cycles(2);

        // idle after reset: park pulses only
        rst = 1'b0;
        clear_meas();
        cycles(300);
        check("idle_pulse_count", pn[0], 3);
        for (int j = 0; j < 3; j++) check("idle_width", pw[0][j], MN);
        check("idle_done", dd[0], 0);
        check("idle_busy", db[0], 0);

        // one-cycle enable on both instances
        clear_meas();
        en[0] = 1'b1;
        en[1] = 1'b1;
        cycles(1);
        check("enable_to_busy", db[0], 1);
        en[0] = 1'b0;
        en[1] = 1'b0;
        wait_done(0, 3000);
        wait_done(1, 10);
        cycles(250);
        check_sweep(0, exp_a);
        check_sweep(1, exp_b);
        check("done_sticky", dd[0], 1);
        check("done_busy_low", db[0], 0);

        // sequencer handshake: clear, then re-enable in the same cycle clear drops
        clr[0] = 1'b1;
        clr[1] = 1'b1;
        cycles(1);
        check("clear_to_done", dd[0], 0);
        clear_meas();
        clr[0] = 1'b0;
        clr[1] = 1'b0;
        en[0]  = 1'b1;
        en[1]  = 1'b1;
        cycles(1);
        en[0] = 1'b0;
        en[1] = 1'b0;
        wait_done(0, 3000);
        cycles(150);
        check_sweep(0, exp_a);
        check_sweep(1, exp_b);

        // abort while the width-20 frame is running
        clr[0] = 1'b1;
        clr[1] = 1'b1;
        cycles(1);
        clr[0] = 1'b0;
        clr[1] = 1'b0;
        clear_meas();
        en[0] = 1'b1;
        cycles(1);
        en[0] = 1'b0;
        k = 0;
        while (last_pw(0) != 15 && k < 1000) begin cycles(1); k++; end
        check("reach_15", last_pw(0), 15);
        k = 0;
        while (dpwm[0] !== 1'b1 && k < 200) begin cycles(1); k++; end
        check("frame20_start", dpwm[0], 1);
        clr[0] = 1'b1;
        cycles(1);
        clr[0] = 1'b0;
        check("abort_busy", db[0], 0);
        base = pn[0];
        cycles(300);
        check("abort_cur_frame", pw[0][base], 20);
        check("abort_next_frame", pw[0][base + 1], MN);
        check("abort_after", pw[0][base + 2], MN);
        check("abort_no_done", dd[0], 0);

        // asynchronous reset in the middle of HOLD
        clear_meas();
        en[0] = 1'b1;
        en[1] = 1'b1;
        cycles(1);
        en[0] = 1'b0;
        en[1] = 1'b0;
        k = 0;
        while (last_pw(0) != 30 && k < 1000) begin cycles(1); k++; end
        check("reach_hold", last_pw(0), 30);
        k = 0;
        while (dpwm[0] !== 1'b1 && k < 200) begin cycles(1); k++; end
        cycles(3);
        check("hold_pwm_high", dpwm[0], 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_pwm",  dpwm[0], 0);
        check("async_rst_busy", db[0],   0);
        for (int i = 0; i < 2; i++) begin
            en[i]  = 1'b1;
            clr[i] = 1'b1;
        end
        cycles(2);
        rst = 1'b0;
        clear_meas();
        cycles(300);
        check("post_rst_pulses", pn[0], 3);
        for (int j = 0; j < 3; j++) check("post_rst_width", pw[0][j], MN);
        check("clear_blocks_enable", db[0], 0);
        for (int i = 0; i < 2; i++) begin
            en[i]  = 1'b0;
            clr[i] = 1'b0;
        end
        cycles(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got timeout expected completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule
